hermes_port_concentrator: RTL and testbench
===========================================

Name: hermes_port_concentrator

Overview:
Parametrised boundary-port concentrator. Lets N_CH peripherals (task injectors, future IO blocks) share one Hermes boundary port of an edge PE, instead of one peripheral per port.
- Outbound (peripherals -> NoC): packet-level round-robin arbitration into an output FIFO.
- Inbound (NoC -> peripherals): header-based channel demux, with drop of unroutable packets.
- Per-channel release gating generalises the single release_peripheral qualifier.

Parameters:
N_CH, 2, number of peripheral channels (2..8)
FLIT_SIZE, 32, flit width in bits
FIFO_DEPTH, 4, outbound FIFO depth (power of 2, >=2)
CH_SEL_LSB, 8, LSB of channel-index field in inbound header flit (field width = clog2(N_CH), min 1)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
release_i  in  N_CH  per-channel enable from PE
ch_rx_i  in  N_CH  peripheral flit valid (outbound)
ch_credit_o  out  N_CH  concentrator can accept peripheral flit
ch_data_i  in  N_CH x FLIT_SIZE  peripheral flits
noc_tx_o  out  1  flit valid to router port
noc_credit_i  in  1  router can accept
noc_data_o  out  FLIT_SIZE  flit to router
noc_rx_i  in  1  flit valid from router
noc_credit_o  out  1  concentrator can accept router flit
noc_data_i  in  FLIT_SIZE  flit from router
ch_tx_o  out  N_CH  flit valid to peripheral
ch_credit_i  in  N_CH  peripheral can accept
ch_data_o  out  N_CH x FLIT_SIZE  flit to peripheral (all channels driven with noc_data_i)
drop_cnt_o  out  8  saturating count of dropped inbound packets

Behaviour:
- Clock and reset: one clock clk_i; reset rst_i is synchronous, active-high.
- Transfer rule: a transfer occurs when valid && credit in the same cycle. Packet format: header flit, size flit (S = payload flit count, unsigned, 0 allowed), then S payload flits.
- Reset (any cycle, including mid-packet):
  - Both FSMs go to IDLE; FIFO empties; RR pointer = 0; drop_cnt_o = 0.
  - All ch_credit_o, noc_tx_o, ch_tx_o, noc_credit_o = 0 while rst_i is high.
  - Partial packets are discarded.
- Outbound FSM, states O_IDLE, O_HDR, O_SIZE, O_PAY:
  - O_IDLE: request = ch_rx_i & release_i. Grant the first requester at or after rr_ptr (wrapping modulo N_CH). Register grant g, go to O_HDR next cycle. No flit is accepted in the grant cycle.
  - ch_credit_o[g] = (state != O_IDLE) && !fifo_full. All other channels read 0.
  - O_HDR: accepted flit -> FIFO, go to O_SIZE.
  - O_SIZE: accepted flit -> FIFO, latch S as remaining count. If S == 0, go to O_IDLE; else go to O_PAY.
  - O_PAY: each accepted flit decrements remaining. On the last flit, go to O_IDLE and set rr_ptr = (g+1) mod N_CH.
  - Packet lock: a release_i[g] drop mid-packet is ignored until the packet ends.
- Outbound FIFO:
  - noc_tx_o = !empty; noc_data_o = head.
  - Pop on noc_tx_o && noc_credit_i.
  - Simultaneous push and pop when full is not allowed (credit already 0). Simultaneous push and pop at any other occupancy keeps occupancy unchanged.
  - Minimum latency: flit accepted in cycle t appears on noc_data_o in cycle t+1.
- Inbound FSM, states I_IDLE, I_SIZE, I_PAY, I_DSIZE, I_DPAY:
  - I_IDLE: idx = noc_data_i[CH_SEL_LSB +: w].
    - Valid target (idx < N_CH && release_i[idx]): ch_tx_o[idx] = noc_rx_i, noc_credit_o = ch_credit_i[idx]. On transfer, latch sel = idx and go to I_SIZE.
    - Invalid target: noc_credit_o = 1, flit discarded, go to I_DSIZE, increment drop_cnt_o (saturate at 255).
  - I_SIZE / I_PAY: forward to sel with zero latency (combinational). Size and count handling are identical to the outbound side. Return to I_IDLE after the last flit, or after the size flit if S == 0.
  - I_DSIZE / I_DPAY: noc_credit_o = 1, ch_tx_o = 0, flits are counted and discarded, return to I_IDLE.
  - The inbound and outbound paths are fully independent and may be active in the same cycle.

Test Plan:
- Reset mid-packet: ch0 sends header, size=3, 1 payload; assert rst_i 1 cycle -> next cycle all valids/credits 0, FIFO empty; a new ch0 packet is delivered intact.
- Round-robin: N_CH=2, both channels continuously request packets of size 2 -> NoC sees ch0, ch1, ch0, ch1 packets with headers unbroken and no interleaved flits.
- Backpressure: noc_credit_i=0 while ch1 sends size=6 -> exactly FIFO_DEPTH=4 flits accepted, then ch_credit_o[1]=0; raising credit drains in order with 1-cycle latency.
- Zero-size packet: ch1 sends header 0x0000_0100, size 0 -> 2 flits out, FSM returns to O_IDLE, rr_ptr=0.
- Inbound demux/drop: header 0x0000_0100 (idx 1) size 2 -> ch_tx_o[1] pulses 4 flits. Header 0x0000_0100 with release_i[1]=0 -> 4 flits consumed, ch_tx_o stays 0, drop_cnt_o=1. 300 drops -> drop_cnt_o=255.
- Release lock: deassert release_i[0] after ch0's size flit (size=3) -> remaining 3 payload flits are still accepted, then ch0 is no longer granted.

Source files
------------

// File: rtl/hermes_port_concentrator.sv
// Hermes boundary-port concentrator: N_CH peripherals share one router port.
// Outbound: packet round-robin into a FIFO. Inbound: header demux and drop.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   release_i           per-channel enable from the PE
//   ch_rx_i/ch_credit_o/ch_data_i    peripheral -> concentrator flits
//   noc_tx_o/noc_credit_i/noc_data_o concentrator -> router flits
//   noc_rx_i/noc_credit_o/noc_data_i router -> concentrator flits
//   ch_tx_o/ch_credit_i/ch_data_o    concentrator -> peripheral flits
//   drop_cnt_o          saturating count of dropped inbound packets
module hermes_port_concentrator #(
  parameter int N_CH       = 2,
  parameter int FLIT_SIZE  = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CH_SEL_LSB = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [N_CH-1:0]                release_i,
  input  logic [N_CH-1:0]                ch_rx_i,
  output logic [N_CH-1:0]                ch_credit_o,
  input  logic [N_CH-1:0][FLIT_SIZE-1:0] ch_data_i,
  output logic                           noc_tx_o,
  input  logic                           noc_credit_i,
  output logic [FLIT_SIZE-1:0]           noc_data_o,
  input  logic                           noc_rx_i,
  output logic                           noc_credit_o,
  input  logic [FLIT_SIZE-1:0]           noc_data_i,
  output logic [N_CH-1:0]                ch_tx_o,
  input  logic [N_CH-1:0]                ch_credit_i,
  output logic [N_CH-1:0][FLIT_SIZE-1:0] ch_data_o,
  output logic [7:0]                     drop_cnt_o
);

  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    O_IDLE, O_HDR, O_SIZE, O_PAY
  } o_state_e;

  typedef enum logic [2:0] {
    I_IDLE, I_SIZE, I_PAY, I_DSIZE, I_DPAY
  } i_state_e;

  o_state_e                          o_state_q, o_state_d;
  logic [CW-1:0]                     gnt_q, gnt_d;
  logic [CW-1:0]                     rr_q, rr_d;
  logic [FLIT_SIZE-1:0]              o_rem_q, o_rem_d;
  logic [FIFO_DEPTH-1:0][FLIT_SIZE-1:0] mem_q, mem_d;
  logic [AW-1:0]                     wr_q, wr_d;
  logic [AW-1:0]                     rd_q, rd_d;
  logic [AW:0]                       cnt_q, cnt_d;

  i_state_e                          i_state_q, i_state_d;
  logic [CW-1:0]                     sel_q, sel_d;
  logic [FLIT_SIZE-1:0]              i_rem_q, i_rem_d;
  logic [7:0]                        drop_q, drop_d;

  logic [N_CH-1:0]      req;
  logic                 found;
  logic [CW-1:0]        pick;
  int                   cand;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic [FLIT_SIZE-1:0] flit_in;

  logic [CW-1:0]        in_idx;
  logic                 in_ok;
  logic [CW-1:0]        tgt;
  logic                 route;
  logic                 in_xfer;

  // Round-robin search starting at rr_q, wrapping modulo N_CH
  always_comb begin
    req   = ch_rx_i & release_i;
    found = 1'b0;
    pick  = rr_q;
    cand  = 0;
    for (int i = 0; i < N_CH; i++) begin
      cand = (int'(rr_q) + i) % N_CH;
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = CW'(cand);
      end
    end
  end

  always_comb begin
    fifo_full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
    fifo_empty = (cnt_q == '0);
    flit_in    = ch_data_i[gnt_q];
    ch_credit_o = '0;
    if (!rst_i && o_state_q != O_IDLE && !fifo_full)
      ch_credit_o[gnt_q] = 1'b1;
    push       = ch_credit_o[gnt_q] && ch_rx_i[gnt_q];
    noc_tx_o   = !rst_i && !fifo_empty;
    pop        = noc_tx_o && noc_credit_i;
    noc_data_o = mem_q[rd_q];

    o_state_d = o_state_q;
    gnt_d     = gnt_q;
    rr_d      = rr_q;
    o_rem_d   = o_rem_q;
    mem_d     = mem_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;

    unique case (o_state_q)
      O_IDLE: begin
        if (found) begin
          gnt_d     = pick;
          o_state_d = O_HDR;
        end
      end
      O_HDR: begin
        if (push) o_state_d = O_SIZE;
      end
      O_SIZE: begin
        if (push) begin
          o_rem_d   = flit_in;
          o_state_d = (flit_in == '0) ? O_IDLE : O_PAY;
        end
      end
      O_PAY: begin
        if (push) begin
          o_rem_d = o_rem_q - 1'b1;
          if (o_rem_q == FLIT_SIZE'(1)) begin
            o_state_d = O_IDLE;
            rr_d = CW'((int'(gnt_q) + 1) % N_CH);
          end
        end
      end
    endcase

    if (push) begin
      mem_d[wr_q] = flit_in;
      wr_d        = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    if (push && !pop) cnt_d = cnt_q + 1'b1;
    if (!push && pop) cnt_d = cnt_q - 1'b1;
  end

  // Header decode is only meaningful in I_IDLE; out-of-range is a drop
  always_comb begin
    in_idx = noc_data_i[CH_SEL_LSB +: CW];
    in_ok  = 1'b0;
    if (int'(in_idx) < N_CH) in_ok = release_i[in_idx];

    tgt   = sel_q;
    route = 1'b0;
    unique case (i_state_q)
      I_IDLE: begin
        tgt   = in_idx;
        route = in_ok;
      end
      I_SIZE, I_PAY: route = 1'b1;
      default: route = 1'b0;
    endcase

    ch_tx_o      = '0;
    noc_credit_o = 1'b0;
    if (!rst_i) begin
      if (route) begin
        ch_tx_o[tgt] = noc_rx_i;
        noc_credit_o = ch_credit_i[tgt];
      end else begin
        noc_credit_o = 1'b1;
      end
    end
    in_xfer = noc_rx_i && noc_credit_o;

    for (int c = 0; c < N_CH; c++) ch_data_o[c] = noc_data_i;

    i_state_d = i_state_q;
    sel_d     = sel_q;
    i_rem_d   = i_rem_q;
    drop_d    = drop_q;

    if (in_xfer) begin
      unique case (i_state_q)
        I_IDLE: begin
          if (in_ok) begin
            sel_d     = in_idx;
            i_state_d = I_SIZE;
          end else begin
            i_state_d = I_DSIZE;
            if (drop_q != 8'hFF) drop_d = drop_q + 1'b1;
          end
        end
        I_SIZE, I_DSIZE: begin
          i_rem_d = noc_data_i;
          if (noc_data_i == '0)
            i_state_d = I_IDLE;
          else if (i_state_q == I_SIZE)
            i_state_d = I_PAY;
          else
            i_state_d = I_DPAY;
        end
        I_PAY, I_DPAY: begin
          i_rem_d = i_rem_q - 1'b1;
          if (i_rem_q == FLIT_SIZE'(1)) i_state_d = I_IDLE;
        end
        default: i_state_d = I_IDLE;
      endcase
    end
  end

  assign drop_cnt_o = drop_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      o_state_q <= O_IDLE;
      gnt_q     <= '0;
      rr_q      <= '0;
      o_rem_q   <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      i_state_q <= I_IDLE;
      sel_q     <= '0;
      i_rem_q   <= '0;
      drop_q    <= '0;
    end else begin
      o_state_q <= o_state_d;
      gnt_q     <= gnt_d;
      rr_q      <= rr_d;
      o_rem_q   <= o_rem_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      i_state_q <= i_state_d;
      sel_q     <= sel_d;
      i_rem_q   <= i_rem_d;
      drop_q    <= drop_d;
    end
  end

  // Storage needs no reset: the pointers define what is valid
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_hermes_port_concentrator.sv
// Scoreboard bench for hermes_port_concentrator: packet-level model of
// per-channel flit streams, round-robin order and inbound demux/drop.
module tb_hermes_port_concentrator;

  localparam int N   = 2;
  localparam int FS  = 32;
  localparam int FD  = 4;
  localparam int LSB = 8;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;

  logic                    clk;
  logic                    rst_i;
  logic [N-1:0]            release_i;
  logic [N-1:0]            ch_rx_i;
  logic [N-1:0]            ch_credit_o;
  logic [N-1:0][FS-1:0]    ch_data_i;
  logic                    noc_tx_o;
  logic                    noc_credit_i;
  logic [FS-1:0]           noc_data_o;
  logic                    noc_rx_i;
  logic                    noc_credit_o;
  logic [FS-1:0]           noc_data_i;
  logic [N-1:0]            ch_tx_o;
  logic [N-1:0]            ch_credit_i;
  logic [N-1:0][FS-1:0]    ch_data_o;
  logic [7:0]              drop_cnt_o;

  hermes_port_concentrator #(
    .N_CH(N), .FLIT_SIZE(FS), .FIFO_DEPTH(FD), .CH_SEL_LSB(LSB)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .release_i(release_i),
    .ch_rx_i(ch_rx_i), .ch_credit_o(ch_credit_o),
    .ch_data_i(ch_data_i), .noc_tx_o(noc_tx_o),
    .noc_credit_i(noc_credit_i), .noc_data_o(noc_data_o),
    .noc_rx_i(noc_rx_i), .noc_credit_o(noc_credit_o),
    .noc_data_i(noc_data_i), .ch_tx_o(ch_tx_o),
    .ch_credit_i(ch_credit_i), .ch_data_o(ch_data_o),
    .drop_cnt_o(drop_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] ch_q  [N][$];
  logic [31:0] exp_q [N][$];
  logic [31:0] in_exp[N][$];
  logic [31:0] noc_q [$];

  int n_vec = 0;
  int n_err = 0;
  int exp_drop = 0;
  int noc_mode = 1;
  int in_mode = 1;
  bit rr_chk = 0;
  int rr_next = 0;
  int seq = 0;
  logic [31:0] last_hdr;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit all_empty();
    bit e = (noc_q.size() == 0);
    for (int c = 0; c < N; c++)
      if (ch_q[c].size() || exp_q[c].size() || in_exp[c].size())
        e = 0;
    return e;
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #3;
    end
  endtask

  task automatic wait_drain(input string name, input int max);
    int k = 0;
    while (k < max && !all_empty()) begin
      cyc(1);
      k++;
    end
    chk(name, 64'(all_empty()), 1);
    cyc(2);
  endtask

  task automatic clear_all();
    for (int c = 0; c < N; c++) begin
      ch_q[c].delete();
      exp_q[c].delete();
      in_exp[c].delete();
    end
    noc_q.delete();
    exp_drop = 0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    clear_all();
    cyc(1);
    rst_i = 1'b0;
    cyc(1);
  endtask

  // Outbound packet from channel c: tag c in [27:24], sequence in [15:0]
  task automatic gen_out(input int c, input int sz);
    logic [31:0] h, f;
    h = 32'hA000_0000 | (32'(c) << 24) | 32'(seq & 16'hFFFF);
    seq++;
    last_hdr = h;
    ch_q[c].push_back(h);
    exp_q[c].push_back(h);
    ch_q[c].push_back(32'(sz));
    exp_q[c].push_back(32'(sz));
    for (int i = 0; i < sz; i++) begin
      f = $urandom;
      ch_q[c].push_back(f);
      exp_q[c].push_back(f);
    end
  endtask

  // Inbound packet: routed if the header's channel field names a
  // released channel, otherwise the whole packet is swallowed
  task automatic gen_in(input logic [31:0] hdr, input int sz);
    int idx;
    bit ok;
    logic [31:0] f;
    idx = int'((hdr >> LSB) & ((32'd1 << CW) - 1));
    ok  = (idx < N) && release_i[idx];
    noc_q.push_back(hdr);
    noc_q.push_back(32'(sz));
    if (ok) begin
      in_exp[idx].push_back(hdr);
      in_exp[idx].push_back(32'(sz));
    end else if (exp_drop < 255) begin
      exp_drop++;
    end
    for (int i = 0; i < sz; i++) begin
      f = $urandom;
      noc_q.push_back(f);
      if (ok) in_exp[idx].push_back(f);
    end
  endtask

  // Peripheral and router drivers
  initial begin
    ch_rx_i      = '0;
    ch_data_i    = '0;
    noc_credit_i = 1'b0;
    noc_rx_i     = 1'b0;
    noc_data_i   = '0;
    ch_credit_i  = '0;
    forever begin
      @(negedge clk);
      for (int c = 0; c < N; c++) begin
        ch_rx_i[c]   = (ch_q[c].size() != 0);
        ch_data_i[c] = ch_rx_i[c] ? ch_q[c][0] : '0;
      end
      case (noc_mode)
        0: noc_credit_i = 1'b0;
        1: noc_credit_i = 1'b1;
        default: noc_credit_i = ($urandom_range(0, 3) != 0);
      endcase
      noc_rx_i   = (noc_q.size() != 0);
      noc_data_i = noc_rx_i ? noc_q[0] : '0;
      ch_credit_i = (in_mode == 1) ? '1 : N'($urandom);
      #1;
      for (int c = 0; c < N; c++)
        if (ch_rx_i[c] && ch_credit_o[c])
          void'(ch_q[c].pop_front());
      if (noc_rx_i && noc_credit_o)
        void'(noc_q.pop_front());
    end
  end

  // Monitor: checks every flit leaving the DUT against the scoreboard
  initial begin
    int mph = 0;
    int mch = 0;
    logic [31:0] mrem = '0;
    logic [31:0] f;
    forever begin
      @(negedge clk);
      #2;
      if (rst_i) begin
        mph = 0;
      end else begin
        if (noc_tx_o && noc_credit_i) begin
          f = noc_data_o;
          if (mph == 0) begin
            mch = int'(f[27:24]);
            chk("out_hdr_tag", 64'(mch < N), 1);
            if (mch >= N) mch = 0;
            if (rr_chk) begin
              chk("rr_order", 64'(mch), 64'(rr_next));
              rr_next = (mch + 1) % N;
            end
            mph = 1;
          end else if (mph == 1) begin
            mrem = f;
            mph = (f == 0) ? 0 : 2;
          end else begin
            mrem = mrem - 1;
            if (mrem == 0) mph = 0;
          end
          if (exp_q[mch].size() == 0)
            chk("out_unexpected", 64'(f), 64'hDEAD);
          else
            chk("out_flit", 64'(f), 64'(exp_q[mch].pop_front()));
        end
        for (int c = 0; c < N; c++) begin
          if (ch_tx_o[c] && ch_credit_i[c]) begin
            if (in_exp[c].size() == 0)
              chk("in_unexpected", 64'(c), 64'hDEAD);
            else
              chk("in_flit", 64'(ch_data_o[c]),
                  64'(in_exp[c].pop_front()));
          end
        end
      end
    end
  end

  initial begin
    int k;
    int acc;
    rst_i     = 1'b1;
    release_i = '1;
    cyc(3);
    chk("rst_ch_credit", 64'(ch_credit_o), 0);
    chk("rst_noc_tx", 64'(noc_tx_o), 0);
    chk("rst_ch_tx", 64'(ch_tx_o), 0);
    chk("rst_noc_credit", 64'(noc_credit_o), 0);
    rst_i = 1'b0;
    cyc(1);
    chk("rst_drop_cnt", 64'(drop_cnt_o), 0);

    // Reset in the middle of a packet
    noc_mode = 0;
    ch_q[0].push_back(32'hA000_0F00);
    ch_q[0].push_back(32'd3);
    ch_q[0].push_back(32'h1234_5678);
    k = 0;
    while (k < 20 && ch_q[0].size() != 0) begin
      cyc(1);
      k++;
    end
    chk("mid_partial_taken", 64'(ch_q[0].size()), 0);
    rst_i = 1'b1;
    clear_all();
    cyc(1);
    chk("mid_rst_ch_credit", 64'(ch_credit_o), 0);
    chk("mid_rst_noc_tx", 64'(noc_tx_o), 0);
    chk("mid_rst_ch_tx", 64'(ch_tx_o), 0);
    chk("mid_rst_noc_credit", 64'(noc_credit_o), 0);
    rst_i = 1'b0;
    cyc(1);
    chk("mid_fifo_empty", 64'(noc_tx_o), 0);
    noc_mode = 1;
    gen_out(0, 3);
    wait_drain("mid_new_pkt", 60);

    // Round-robin with both channels always requesting
    do_reset();
    rr_chk = 1;
    rr_next = 0;
    for (int i = 0; i < 4; i++) begin
      gen_out(0, 2);
      gen_out(1, 2);
    end
    wait_drain("rr_drain", 200);
    rr_chk = 0;

    // Backpressure: FIFO fills, then drains in order
    do_reset();
    noc_mode = 0;
    gen_out(1, 6);
    k = 0;
    while (k < 20 && ch_q[1].size() > 7) begin
      cyc(1);
      k++;
    end
    cyc(1);
    chk("lat_tx", 64'(noc_tx_o), 1);
    chk("lat_data", 64'(noc_data_o), 64'(last_hdr));
    cyc(12);
    acc = 8 - ch_q[1].size();
    chk("bp_accepted", 64'(acc), 64'(FD));
    chk("bp_credit", 64'(ch_credit_o[1]), 0);
    noc_mode = 1;
    wait_drain("bp_drain", 60);

    // Zero-size packet; rr pointer stays at channel 0
    do_reset();
    ch_q[1].push_back(32'h0100_0100);
    exp_q[1].push_back(32'h0100_0100);
    ch_q[1].push_back(32'd0);
    exp_q[1].push_back(32'd0);
    wait_drain("zero_drain", 40);
    chk("zero_idle", 64'(ch_credit_o), 0);
    rr_chk = 1;
    rr_next = 0;
    gen_out(1, 1);
    gen_out(0, 1);
    wait_drain("zero_rr_drain", 60);
    rr_chk = 0;

    // Release drop mid-packet is ignored until the packet ends
    do_reset();
    gen_out(0, 3);
    gen_out(0, 3);
    k = 0;
    while (k < 20 && ch_q[0].size() > 8) begin
      cyc(1);
      k++;
    end
    release_i[0] = 1'b0;
    k = 0;
    while (k < 40 && exp_q[0].size() > 5) begin
      cyc(1);
      k++;
    end
    chk("lock_pkt_done", 64'(exp_q[0].size()), 5);
    cyc(10);
    chk("lock_no_regrant", 64'(ch_q[0].size()), 5);
    chk("lock_credit", 64'(ch_credit_o[0]), 0);
    ch_q[0].delete();
    exp_q[0].delete();
    release_i = '1;

    // Inbound demux and drop
    do_reset();
    gen_in(32'h0000_0100, 2);
    wait_drain("in_route", 40);
    chk("in_no_drop", 64'(drop_cnt_o), 64'(exp_drop));
    release_i[1] = 1'b0;
    gen_in(32'h0000_0100, 2);
    wait_drain("in_drop", 40);
    chk("in_drop_one", 64'(drop_cnt_o), 64'(exp_drop));
    for (int i = 0; i < 300; i++)
      gen_in(($urandom & 32'hFFFF_FEFF) | 32'h100, 0);
    wait_drain("in_drop_many", 2000);
    chk("in_drop_sat", 64'(drop_cnt_o), 255);
    release_i = '1;

    // Random concurrent traffic in both directions
    do_reset();
    noc_mode = 2;
    in_mode = 2;
    rr_chk = 1;
    rr_next = 0;
    for (int i = 0; i < 6; i++) begin
      gen_out(0, $urandom_range(1, 5));
      gen_out(1, $urandom_range(1, 5));
    end
    for (int i = 0; i < 10; i++)
      gen_in($urandom, $urandom_range(0, 4));
    wait_drain("rand_drain", 3000);
    chk("rand_drop", 64'(drop_cnt_o), 64'(exp_drop));
    rr_chk = 0;

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
